mem_stage: RTL

Memory-access stage of the five-stage pipeline, consuming the EX/MEM pipeline register outputs. It turns the ALU result and the store data into a request/acknowledge transaction on the data-memory port. It stalls upstream stages while a transaction is outstanding and drives the MEM/WB pipeline register toward write-back. Non-memory instructions pass through with one-cycle latency.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 25 ++
 rtl/mem_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory-access stage: FSM states, widths, MEM/WB bundle.
package pipe_pkg;

    localparam int REG_NUM_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [DATA_W-1:0]    alu_result;
        logic [DATA_W-1:0]    read_data;
        logic [REG_NUM_W-1:0] rd_num;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: whole bundle captured when i_load is high.
// Latency 1 cycle; no backpressure (holds contents while i_load is low).
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_load,
    input  mem_wb_t i_d,
    output mem_wb_t o_q
);

    mem_wb_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM slot -> dmem req/ack -> MEM/WB. Latency 1 cycle (non-mem), 1+N (mem).
// Stalls upstream while a request is outstanding. MEM_TIMEOUT_EN adds an ack timeout with bus_err abort.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_write_en,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [4:0]        rd_num,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [4:0]        wb_rd_num,
    output logic              misalign_err,
    output logic              bus_err
);

    import pipe_pkg::*;

    mem_state_t            r_state;
    logic                  r_we;
    logic                  r_m2r;
    logic                  r_rw;
    logic [DATA_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [REG_NUM_W-1:0]  r_rd;
    logic                  r_misalign;

    logic    w_mem_op;
    logic    w_aligned;
    logic    w_abort;
    logic    w_wb_ld;
    mem_wb_t w_wb_d;
    mem_wb_t w_wb_q;

    assign w_mem_op  = in_valid & (mem_write_en | mem_to_reg);
    assign w_aligned = (alu_result[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_bus_err;

    // Ack on the last allowed cycle still completes normally.
    assign w_abort = (r_state == ACCESS) && !dmem_ack && (r_tmo_cnt == 8'(TIMEOUT - 1));
    assign bus_err = r_bus_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (r_state == IDLE) begin
                r_tmo_cnt <= '0;
            end else if (!dmem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end
`else
    logic w_unused_tmo;

    assign w_abort      = 1'b0;
    assign bus_err      = 1'b0;
    assign w_unused_tmo = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_m2r      <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        if (w_aligned) begin
                            r_we    <= mem_write_en;
                            r_m2r   <= mem_to_reg & ~mem_write_en;
                            r_rw    <= reg_write;
                            r_addr  <= alu_result;
                            r_wdata <= read_data_2;
                            r_rd    <= rd_num;
                            r_state <= ACCESS;
                        end else begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack || w_abort) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // MEM/WB next value: IDLE samples every edge, ACCESS only on completion or abort.
    always_comb begin
        w_wb_ld = 1'b0;
        w_wb_d  = w_wb_q;
        if (r_state == IDLE) begin
            w_wb_ld = 1'b1;
            if (!in_valid || (w_mem_op && w_aligned)) begin
                w_wb_d.valid = 1'b0;
            end else begin
                w_wb_d = '{valid:      1'b1,
                           reg_write:  reg_write & ~w_mem_op,
                           mem_to_reg: 1'b0,
                           alu_result: alu_result,
                           read_data:  '0,
                           rd_num:     rd_num};
            end
        end else if (dmem_ack) begin
            w_wb_ld = 1'b1;
            w_wb_d  = '{valid:      1'b1,
                        reg_write:  r_rw,
                        mem_to_reg: r_m2r,
                        alu_result: r_addr,
                        read_data:  r_m2r ? dmem_rdata : '0,
                        rd_num:     r_rd};
        end else if (w_abort) begin
            w_wb_ld = 1'b1;
            w_wb_d  = '{valid:      1'b1,
                        reg_write:  1'b0,
                        mem_to_reg: 1'b0,
                        alu_result: r_addr,
                        read_data:  '0,
                        rd_num:     r_rd};
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_wb_ld),
        .i_d    (w_wb_d),
        .o_q    (w_wb_q)
    );

    assign mem_stall = rst_n & (((r_state == IDLE) & w_mem_op & w_aligned) |
                                ((r_state == ACCESS) & ~dmem_ack & ~w_abort));

    assign dmem_req      = (r_state == ACCESS);
    assign dmem_we       = (r_state == ACCESS) & r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign misalign_err  = r_misalign;
    assign wb_valid      = w_wb_q.valid;
    assign wb_reg_write  = w_wb_q.reg_write;
    assign wb_mem_to_reg = w_wb_q.mem_to_reg;
    assign wb_alu_result = w_wb_q.alu_result;
    assign wb_read_data  = w_wb_q.read_data;
    assign wb_rd_num     = w_wb_q.rd_num;

endmodule
